// File: rtl/axi_dram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_dram_slave_if
// Purpose : AXI4 bundle between the ISP *_s_inf master port and the on-chip
//           DRAM replacement slave.
// Modports: slave  - AW/W/AR/bready/rready in;  ready/B/R out (axi_dram_slave)
//           master - mirror image, used by the ISP side or a testbench.
// ---------------------------------------------------------------------------
interface axi_dram_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4
) ();
    // write address channel
    logic [ID_W-1:0]   awid_s_inf;
    logic [ADDR_W-1:0] awaddr_s_inf;
    logic [2:0]        awsize_s_inf;
    logic [1:0]        awburst_s_inf;
    logic [7:0]        awlen_s_inf;
    logic              awvalid_s_inf;
    logic              awready_s_inf;
    // write data channel
    logic [DATA_W-1:0] wdata_s_inf;
    logic              wlast_s_inf;
    logic              wvalid_s_inf;
    logic              wready_s_inf;
    // write response channel
    logic [ID_W-1:0]   bid_s_inf;
    logic [1:0]        bresp_s_inf;
    logic              bvalid_s_inf;
    logic              bready_s_inf;
    // read address channel
    logic [ID_W-1:0]   arid_s_inf;
    logic [ADDR_W-1:0] araddr_s_inf;
    logic [7:0]        arlen_s_inf;
    logic [2:0]        arsize_s_inf;
    logic [1:0]        arburst_s_inf;
    logic              arvalid_s_inf;
    logic              arready_s_inf;
    // read data channel
    logic [ID_W-1:0]   rid_s_inf;
    logic [DATA_W-1:0] rdata_s_inf;
    logic [1:0]        rresp_s_inf;
    logic              rlast_s_inf;
    logic              rvalid_s_inf;
    logic              rready_s_inf;

    modport slave (
        input  awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        output awready_s_inf,
        input  wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        output wready_s_inf,
        output bid_s_inf, bresp_s_inf, bvalid_s_inf,
        input  bready_s_inf,
        input  arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        output arready_s_inf,
        output rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        input  rready_s_inf
    );

    modport master (
        output awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        input  awready_s_inf,
        output wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        input  wready_s_inf,
        input  bid_s_inf, bresp_s_inf, bvalid_s_inf,
        output bready_s_inf,
        output arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        input  arready_s_inf,
        input  rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        output rready_s_inf
    );
endinterface

// File: rtl/axi_dram_slave.sv
// ---------------------------------------------------------------------------
// axi_dram_slave
// Purpose : AXI4 slave serving 128-bit INCR bursts from an on-chip word array.
//           Independent write and read engines, one outstanding transaction
//           each, programmable read latency (RD_LAT, 1..15).
// Ports   : clk - single rising-edge clock
//           rst - synchronous active-high reset (control state only)
//           axi - axi_dram_slave_if.slave bundle (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module axi_dram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 128,
    parameter int                ID_W      = 4,
    parameter int                MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000,
    parameter int                RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_dram_slave_if.slave      axi
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    // One extra address bit so a burst walking past the top never wraps back
    // into the window.
    localparam logic [ADDR_W:0] L_BASE     = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] L_END      = L_BASE + ((ADDR_W+1)'(MEM_WORDS) << 4);
    localparam logic [ADDR_W:0] L_BEAT     = (ADDR_W+1)'(16);
    localparam logic [3:0]      L_LAT_INIT = 4'(RD_LAT - 1);

    localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

    function automatic logic f_in_range(input logic [ADDR_W:0] a);
        return (a >= L_BASE) && (a < L_END);
    endfunction

    function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_W:0] a);
        return IDX_W'((a - L_BASE) >> 4);
    endfunction

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    // ---------------- write engine ----------------
    logic [1:0]        r_wstate;
    logic [ID_W-1:0]   r_wid;
    logic [ADDR_W:0]   r_waddr;
    logic [7:0]        r_wlen, r_wcnt;
    logic              r_wlegal, r_werr;
    logic              r_awready, r_wready, r_bvalid;
    logic [ID_W-1:0]   r_bid;
    logic [1:0]        r_bresp;

    logic w_aw_hs, w_aw_legal, w_w_hs, w_w_last, w_w_beat_ok, w_w_err_next, w_mem_we;
    assign w_aw_hs      = axi.awvalid_s_inf && r_awready;
    assign w_aw_legal   = (axi.awsize_s_inf == 3'b100) && (axi.awburst_s_inf == 2'b01);
    assign w_w_hs       = (r_wstate == W_DATA) && axi.wvalid_s_inf && r_wready;
    assign w_w_last     = (r_wcnt == r_wlen);
    assign w_w_beat_ok  = r_wlegal && f_in_range(r_waddr);
    // Any dropped beat or misplaced wlast makes the whole burst SLVERR.
    assign w_w_err_next = r_werr || !w_w_beat_ok || (axi.wlast_s_inf != w_w_last);
    // A beat landing on a reset edge is discarded along with the burst.
    assign w_mem_we     = w_w_hs && w_w_beat_ok && !rst;

    // Write FSM: AW accept, beat counting, B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= 8'd0;
            r_wcnt    <= 8'd0;
            r_wlegal  <= 1'b0;
            r_werr    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wid     <= axi.awid_s_inf;
                        r_waddr   <= {1'b0, axi.awaddr_s_inf};
                        r_wlen    <= axi.awlen_s_inf;
                        r_wcnt    <= 8'd0;
                        r_wlegal  <= w_aw_legal;
                        r_werr    <= !w_aw_legal;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_werr <= w_w_err_next;
                        // Burst length comes from awlen; wlast only grades it.
                        if (w_w_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wid;
                            r_bresp  <= w_w_err_next ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wcnt  <= r_wcnt + 8'd1;
                            r_waddr <= r_waddr + L_BEAT;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bready_s_inf) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Array write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[f_index(r_waddr)] <= axi.wdata_s_inf;
        end
    end

    // ---------------- read engine ----------------
    logic [1:0]        r_rstate;
    logic [ADDR_W:0]   r_raddr;
    logic [7:0]        r_rlen, r_rcnt;
    logic              r_rlegal, r_rok;
    logic [3:0]        r_lat;
    logic              r_arready, r_rvalid, r_rlast;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_ar_hs, w_ar_legal, w_ar_ok, w_r_hs;
    logic [ADDR_W:0]   w_ar_first, w_ar_final, w_beat_addr;
    logic [DATA_W-1:0] w_beat_data;
    assign w_ar_hs    = axi.arvalid_s_inf && r_arready;
    assign w_ar_legal = (axi.arsize_s_inf == 3'b100) && (axi.arburst_s_inf == 2'b01);
    assign w_ar_first = {1'b0, axi.araddr_s_inf};
    assign w_ar_final = w_ar_first + ((ADDR_W+1)'(axi.arlen_s_inf) << 4);
    // The window is contiguous, so every beat is in range iff both ends are.
    assign w_ar_ok    = w_ar_legal && f_in_range(w_ar_first) && f_in_range(w_ar_final);
    assign w_r_hs     = r_rvalid && axi.rready_s_inf;
    // Beat 0 loads from the latched address; later beats from the next one.
    assign w_beat_addr = (r_rstate == R_WAIT) ? r_raddr : (r_raddr + L_BEAT);
    assign w_beat_data = (r_rlegal && f_in_range(w_beat_addr)) ? r_mem[f_index(w_beat_addr)] : '0;

    // Read FSM: AR accept, latency countdown, R beat delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_raddr   <= '0;
            r_rlen    <= 8'd0;
            r_rcnt    <= 8'd0;
            r_rlegal  <= 1'b0;
            r_rok     <= 1'b0;
            r_lat     <= 4'd0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid     <= axi.arid_s_inf;
                        r_raddr   <= w_ar_first;
                        r_rlen    <= axi.arlen_s_inf;
                        r_rcnt    <= 8'd0;
                        r_rlegal  <= w_ar_legal;
                        r_rok     <= w_ar_ok;
                        r_lat     <= L_LAT_INIT;
                        r_arready <= 1'b0;
                        r_rstate  <= R_WAIT;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_rdata  <= w_beat_data;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_rlen == 8'd0);
                        r_rresp  <= r_rok ? RESP_OKAY : RESP_SLVERR;
                        r_rstate <= R_DATA;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                R_DATA: begin
                    // Outputs hold while rready is low.
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr <= r_raddr + L_BEAT;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rdata <= w_beat_data;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    assign axi.awready_s_inf = r_awready;
    assign axi.wready_s_inf  = r_wready;
    assign axi.bvalid_s_inf  = r_bvalid;
    assign axi.bid_s_inf     = r_bid;
    assign axi.bresp_s_inf   = r_bresp;
    assign axi.arready_s_inf = r_arready;
    assign axi.rvalid_s_inf  = r_rvalid;
    assign axi.rid_s_inf     = r_rid;
    assign axi.rdata_s_inf   = r_rdata;
    assign axi.rresp_s_inf   = r_rresp;
    assign axi.rlast_s_inf   = r_rlast;
endmodule

// File: doc/axi_dram_slave.md
# axi_dram_slave

Synthesizable AXI4 slave (responder) that terminates the ISP's `*_s_inf` master port and serves it from an on-chip word array. It replaces the behavioural DRAM model when the ISP is exercised in emulation or full-chip simulation. It accepts 128-bit INCR read and write bursts with independent read and write engines, one outstanding transaction per direction, and a programmable read latency.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 128, data beat width (16 bytes).
- `ID_W`, 4, transaction ID width.
- `MEM_WORDS`, 4096, array depth in 128-bit words.
- `BASE_ADDR`, 32'h0001_0000, byte address of word 0.
- `RD_LAT`, 2, cycles from AR handshake to first `rvalid`; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `awid_s_inf` in 4, `awaddr_s_inf` in 32, `awsize_s_inf` in 3, `awburst_s_inf` in 2, `awlen_s_inf` in 8, `awvalid_s_inf` in 1: write address channel.
- `awready_s_inf`  out  1  write address accept.
- `wdata_s_inf` in 128, `wlast_s_inf` in 1, `wvalid_s_inf` in 1: write data channel.
- `wready_s_inf`  out  1  write data accept.
- `bid_s_inf` out 4, `bresp_s_inf` out 2, `bvalid_s_inf` out 1: write response channel.
- `bready_s_inf`  in  1  response accept.
- `arid_s_inf` in 4, `araddr_s_inf` in 32, `arlen_s_inf` in 8, `arsize_s_inf` in 3, `arburst_s_inf` in 2, `arvalid_s_inf` in 1: read address channel.
- `arready_s_inf`  out  1  read address accept.
- `rid_s_inf` out 4, `rdata_s_inf` out 128, `rresp_s_inf` out 2, `rlast_s_inf` out 1, `rvalid_s_inf` out 1: read data channel.
- `rready_s_inf`  in  1  read data accept.

## Operation
- Word index = (addr − BASE_ADDR) >> 4. Address bits [3:0] are ignored.
- A beat is in range when BASE_ADDR ≤ addr and its index < MEM_WORDS. The index increments by 1 per beat, with no wrap.
- A burst is legal when size = 3'b100 and burst = 2'b01 (INCR). An illegal burst still transfers awlen+1 / arlen+1 beats, with all writes dropped and all read data returned as 0.
- Response code: OKAY (2'b00) when every beat is legal and in range and the write `wlast` is correct. Otherwise SLVERR (2'b10). An out-of-range beat drops its write or reads 0.

Write FSM:
- W_IDLE: `awready`=1. On AW handshake, latch id, addr, len and legality, clear the beat counter, and go to W_DATA.
- W_DATA: `wready`=1. On each W handshake, write the beat if legal and in range, then increment the address and counter.
  - The burst ends when counter = awlen, regardless of `wlast`.
  - `wlast` asserted early, or missing on the final beat, forces SLVERR.
  - The final beat goes to W_RESP.
- W_RESP: `bvalid`=1 with latched `bid`/`bresp`, held until `bready`, then W_IDLE.

Read FSM:
- R_IDLE: `arready`=1. On AR handshake, latch fields and load the latency counter with RD_LAT−1.
- R_WAIT: count down. At 0, load `rdata` for beat 0 and go to R_DATA with `rvalid`=1.
- R_DATA: `rdata`, `rid`, `rresp` and `rlast` are held stable while `rready`=0.
  - On handshake, load the next beat.
  - `rlast`=1 on beat arlen; its handshake returns to R_IDLE.
  - `rresp` carries the burst-level code, evaluated at AR accept, on every beat.

Shared rules:
- The read and write engines run concurrently.
- Same-word collision: a write and a read-beat load on the same edge return old data to the read.
- The array is never reset. Only control state and outputs are reset.

## Timing
- All outputs are registered.
- While `rst`=1: all valid and ready outputs are 0, and id/resp/last/data outputs are 0.
- First cycle after `rst` falls: `awready`=`arready`=1.
- `awready` and `arready` drop in the cycle after their handshake. `wready` is 1 from the cycle after the AW handshake.
- `bvalid` rises in the cycle after the last W handshake.
- The first `rvalid` appears RD_LAT cycles after the AR handshake edge. With `rready` held at 1, throughput is one beat per cycle.
- Reset mid-burst: both FSMs return to IDLE and no B or R response is issued. Words already written persist.

## Test plan
- Write a 4-beat INCR burst to 0x10000 (len=3, id=5, data 0..3), `bready`=1 → `wready` for 4 cycles, then `bvalid` with bid=5 and bresp=00. Read it back with len=3 → data 0..3, `rlast` on beat 3, rresp=00, first `rvalid` 2 cycles after AR.
- Read with `rready` toggling 1,0,0,1 → `rdata` stable during stalls, no beat lost or duplicated.
- Write starting at word MEM_WORDS−1 with len=1 → bresp=10. The in-range word is written; the out-of-range beat is dropped.
- awburst=2'b10 (WRAP), len=0 → bresp=10, memory unchanged. A read with arsize=3'b011 → rdata=0, rresp=10.
- AW and AR issued in the same cycle to different words → both complete independently with correct data. A write and a read to the same word on the same edge → the read returns old data.
- `rst` asserted mid-read on beat 2 of 8 → `rvalid`=0 the next cycle. After release, `arready`=1 and a new burst completes normally.
